// File: rtl/sseg_scan_ctrl_if.sv
// rtl/sseg_scan_ctrl_if.sv - requester/display bundle for the seven-segment scan controller
//
// Purpose: carries the two requester inputs and the latched display outputs
// of sseg_scan_ctrl as one bundle.
// Signals:
//   req0/req1         requester wants the display
//   data0/data1       requester 16-bit value
//   hex_dec0/hex_dec1 requester format (1 = hex, 0 = decimal)
//   sign0/sign1       requester minus-sign enable
//   data, hex_dec, sign  latched value/format/sign for the display datapath
//   digit_sel         active digit, 0 = rightmost
//   blank             1 = no owner, all anodes off
//   grant             one-hot owner, 00 = none
//   frame_tick        one-cycle pulse at each frame start
// Modports: master = requester side / display consumer, slave = controller.

interface sseg_scan_ctrl_if;
  logic        req0;
  logic [15:0] data0;
  logic        hex_dec0;
  logic        sign0;
  logic        req1;
  logic [15:0] data1;
  logic        hex_dec1;
  logic        sign1;
  logic [15:0] data;
  logic        hex_dec;
  logic        sign;
  logic [1:0]  digit_sel;
  logic        blank;
  logic [1:0]  grant;
  logic        frame_tick;

  modport master (
    output req0, data0, hex_dec0, sign0,
    output req1, data1, hex_dec1, sign1,
    input  data, hex_dec, sign, digit_sel, blank, grant, frame_tick
  );

  modport slave (
    input  req0, data0, hex_dec0, sign0,
    input  req1, data1, hex_dec1, sign1,
    output data, hex_dec, sign, digit_sel, blank, grant, frame_tick
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - two-requester arbiter and digit scanner for a 4-digit display
//
// Purpose: scans four display digits at DIV clocks per digit and hands the
// display to one of two requesters. Ownership changes only at a frame
// boundary (last cycle of digit 3), so a frame never shows two values.
// Ties are broken round-robin.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sseg_scan_ctrl_if.slave: requester inputs, display outputs

module sseg_scan_ctrl #(
  parameter int DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  sseg_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       digit_sel, digit_sel_nxt;
  logic [15:0]      data_q, data_nxt;
  logic             hex_dec_q, hex_dec_nxt;
  logic             sign_q, sign_nxt;
  logic             tick_q, tick_nxt;
  // 1 = requester 1 was granted last; reset value makes requester 0 win the first tie
  logic             last_q, last_nxt;

  logic sel_valid;
  logic sel_one;
  logic fb;

  // Pick a winner from the current requests; only consumed when arbitration is allowed.
  always_comb begin
    sel_valid = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      sel_one = ~last_q;
    end else begin
      sel_one = bus.req1;
    end
  end

  assign fb = (cnt == CNT_MAX) && (digit_sel == 2'd3);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    digit_sel_nxt = digit_sel;
    data_nxt      = data_q;
    hex_dec_nxt   = hex_dec_q;
    sign_nxt      = sign_q;
    tick_nxt      = 1'b0;
    last_nxt      = last_q;

    case (state)
      IDLE: begin
        cnt_nxt       = '0;
        digit_sel_nxt = 2'd0;
      end
      OWN0, OWN1: begin
        if (cnt == CNT_MAX) begin
          cnt_nxt       = '0;
          digit_sel_nxt = digit_sel + 2'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        // Losing all requesters at the frame boundary blanks the display but keeps the last value.
        if (fb && !sel_valid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt     = IDLE;
        cnt_nxt       = '0;
        digit_sel_nxt = 2'd0;
      end
    endcase

    // A grant always starts a fresh frame and re-latches the winner's value.
    if (((state == IDLE) || fb) && sel_valid) begin
      state_nxt     = sel_one ? OWN1 : OWN0;
      cnt_nxt       = '0;
      digit_sel_nxt = 2'd0;
      data_nxt      = sel_one ? bus.data1 : bus.data0;
      hex_dec_nxt   = sel_one ? bus.hex_dec1 : bus.hex_dec0;
      sign_nxt      = sel_one ? bus.sign1 : bus.sign0;
      tick_nxt      = 1'b1;
      last_nxt      = sel_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      digit_sel <= 2'd0;
      data_q    <= 16'h0000;
      hex_dec_q <= 1'b0;
      sign_q    <= 1'b0;
      tick_q    <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      digit_sel <= digit_sel_nxt;
      data_q    <= data_nxt;
      hex_dec_q <= hex_dec_nxt;
      sign_q    <= sign_nxt;
      tick_q    <= tick_nxt;
      last_q    <= last_nxt;
    end
  end

  assign bus.data       = data_q;
  assign bus.hex_dec    = hex_dec_q;
  assign bus.sign       = sign_q;
  assign bus.digit_sel  = digit_sel;
  assign bus.frame_tick = tick_q;
  assign bus.blank      = (state == IDLE);
  assign bus.grant      = (state == OWN0) ? 2'b01 :
                          (state == OWN1) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - self-checking bench for sseg_scan_ctrl

module tb_sseg_scan_ctrl;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sseg_scan_ctrl_if bus ();

  sseg_scan_ctrl #(.DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: owner (0 none, 1 req0, 2 req1) and cycle position within the frame.
  int          m_own;
  int          m_pos;
  logic [15:0] m_data;
  logic        m_hex;
  logic        m_sign;
  logic        m_last;
  logic        m_tick;

  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] obs_vec();
    return {bus.grant, bus.blank, bus.digit_sel, bus.frame_tick, bus.hex_dec, bus.sign, bus.data};
  endfunction

  function automatic logic [23:0] model_vec();
    logic [1:0] g;
    logic [1:0] ds;
    g  = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
    ds = 2'(m_pos / DIV);
    return {g, (m_own == 0), ds, m_tick, m_hex, m_sign, m_data};
  endfunction

  task automatic model_reset();
    m_own  = 0;
    m_pos  = 0;
    m_data = 16'h0000;
    m_hex  = 1'b0;
    m_sign = 1'b0;
    m_last = 1'b1;
    m_tick = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic any;
    logic pick;
    logic do_grant;
    any      = bus.req0 | bus.req1;
    pick     = (bus.req0 && bus.req1) ? ~m_last : bus.req1;
    do_grant = 1'b0;
    m_tick   = 1'b0;
    if (m_own == 0) begin
      do_grant = any;
    end else if (m_pos == FRAME - 1) begin
      if (any) do_grant = 1'b1;
      else begin
        m_own = 0;
        m_pos = 0;
      end
    end else begin
      m_pos++;
    end
    if (do_grant) begin
      m_own  = pick ? 2 : 1;
      m_pos  = 0;
      m_data = pick ? bus.data1 : bus.data0;
      m_hex  = pick ? bus.hex_dec1 : bus.hex_dec0;
      m_sign = pick ? bus.sign1 : bus.sign0;
      m_last = pick;
      m_tick = 1'b1;
    end
  endtask

  // Inputs are set before calling; one rising edge, then compare against the scoreboard.
  task automatic step();
    model_step();
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    chk("cycle", obs_vec(), exp_q.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_tick(input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!bus.frame_tick && k < 2 * FRAME);
    chk({tag, "_tick_seen"}, 24'(bus.frame_tick), 24'd1);
  endtask

  initial begin
    bus.req0 = 0; bus.data0 = 16'h0000; bus.hex_dec0 = 0; bus.sign0 = 0;
    bus.req1 = 0; bus.data1 = 16'h0000; bus.hex_dec1 = 0; bus.sign1 = 0;
    model_reset();

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("reset_async", obs_vec(), model_vec());
    chk("reset_blank", 24'(bus.blank), 24'd1);
    @(posedge clk); #1;
    chk("reset_held", obs_vec(), model_vec());
    rst_n = 1'b1;
    run(3);

    // Tie from IDLE: requester 0 wins first, then alternate at each frame boundary
    bus.req0 = 1; bus.data0 = 16'h1111; bus.hex_dec0 = 1; bus.sign0 = 0;
    bus.req1 = 1; bus.data1 = 16'h2222; bus.hex_dec1 = 0; bus.sign1 = 1;
    step();
    chk("tie_first_grant", 24'(bus.grant), 24'h1);
    chk("tie_first_data", 24'(bus.data), 24'h1111);
    run_until_tick("tie_sw1");
    chk("tie_second_grant", 24'(bus.grant), 24'h2);
    chk("tie_second_data", 24'(bus.data), 24'h2222);
    run_until_tick("tie_sw2");
    chk("tie_third_grant", 24'(bus.grant), 24'h1);
    run(FRAME - 1);

    // Requester 1 leaves; requester 0 takes over with 1234 at the next boundary
    bus.req1 = 0;
    bus.data0 = 16'h1234; bus.hex_dec0 = 0; bus.sign0 = 1;
    run_until_tick("single");
    chk("single_grant", 24'(bus.grant), 24'h1);
    chk("single_data", 24'(bus.data), 24'h1234);
    run(2 * FRAME);

    // No tearing: new data mid-frame is ignored until the boundary
    while (m_pos != 5) step();
    bus.data0 = 16'hABCD;
    step();
    chk("tear_hold", 24'(bus.data), 24'h1234);
    run_until_tick("tear");
    chk("tear_update", 24'(bus.data), 24'hABCD);

    // Release: frame completes, then blank with data retained
    bus.req0 = 0;
    for (int k = 0; k < 2 * FRAME && !bus.blank; k++) step();
    chk("rel_grant", 24'(bus.grant), 24'h0);
    chk("rel_blank", 24'(bus.blank), 24'd1);
    chk("rel_digit", 24'(bus.digit_sel), 24'd0);
    chk("rel_data", 24'(bus.data), 24'hABCD);
    run(4);

    // Mid-frame reset at digit 2
    bus.req1 = 1; bus.data1 = 16'h5A5A; bus.hex_dec1 = 1; bus.sign1 = 1;
    step();
    chk("mr_grant", 24'(bus.grant), 24'h2);
    for (int k = 0; k < FRAME && bus.digit_sel != 2'd2; k++) step();
    chk("mr_at_digit2", 24'(bus.digit_sel), 24'd2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mr_async", obs_vec(), model_vec());
    chk("mr_data_cleared", 24'(bus.data), 24'h0);
    @(posedge clk); #1;
    chk("mr_held", obs_vec(), model_vec());
    rst_n = 1'b1;
    step();
    chk("mr_regrant", 24'(bus.grant), 24'h2);
    chk("mr_regrant_tick", 24'(bus.frame_tick), 24'd1);
    run(FRAME + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 100000, meaning clock cycles per digit slot; legal range DIV >= 2.
REQ-002 SHALL have ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 wants the display.
- data0  in  16  requester 0 value.
- hex_dec0  in  1  requester 0 format: 1 = hex, 0 = decimal.
- sign0  in  1  requester 0 minus-sign enable.
- req1  in  1  requester 1 wants the display.
- data1  in  16  requester 1 value.
- hex_dec1  in  1  requester 1 format.
- sign1  in  1  requester 1 minus-sign enable.
- data  out  16  latched value to the 4-digit display datapath.
- hex_dec  out  1  latched format.
- sign  out  1  latched sign.
- digit_sel  out  2  active digit index, 0 = rightmost.
- blank  out  1  1 = no owner; top level forces all anodes off.
- grant  out  2  one-hot owner; 00 = none.
- frame_tick  out  1  one-cycle pulse at each frame start.
REQ-003 SHALL use one clock (clk) and an asynchronous, active-low reset (rst_n); these are fixed.

Function
REQ-004 SHALL keep a prescaler cnt counting 0..DIV-1; when cnt == DIV-1, cnt wraps to 0 and digit_sel increments, wrapping 3 -> 0.
REQ-005 SHALL define a frame boundary (FB) as cnt == DIV-1 and digit_sel == 3; one frame is 4*DIV cycles.
REQ-006 SHALL implement states IDLE (grant = 00, blank = 1), OWN0 (grant = 01), OWN1 (grant = 10); blank = 0 in OWN0 and OWN1.
REQ-007 In IDLE, cnt and digit_sel SHALL be held at 0.
REQ-008 In IDLE with any req asserted, the next edge SHALL grant a requester, latch its data, hex_dec and sign, set cnt = 0 and digit_sel = 0, and pulse frame_tick; this is 1-cycle latency.
REQ-009 In OWN0 or OWN1, arbitration SHALL occur only at FB, with the result registered on the FB edge:
- both req -> grant the requester not granted last (round-robin);
- one req -> grant that requester;
- none -> go to IDLE with outputs per REQ-013.
REQ-010 On every FB edge that grants, outputs data, hex_dec and sign SHALL be re-latched from the granted requester and frame_tick SHALL pulse for one cycle.
REQ-011 data, hex_dec and sign SHALL NOT change except on a grant edge, so no frame mixes two values.
REQ-012 If the owner drops req mid-frame, the current frame SHALL complete unchanged; the drop takes effect only at FB.
REQ-013 On the transition to IDLE: blank = 1, grant = 00, cnt = 0, digit_sel = 0; data, hex_dec and sign retain their last values.
REQ-014 A last-grant pointer SHALL be updated on every grant and read only for ties; after reset it points at requester 1, so requester 0 wins the first tie.
REQ-015 frame_tick SHALL be 0 in all cycles other than those specified in REQ-008 and REQ-010.

Reset
REQ-016 While rst_n = 0, regardless of clk, outputs SHALL be: state IDLE, cnt = 0, digit_sel = 0, grant = 00, blank = 1, data = 16'h0000, hex_dec = 0, sign = 0, frame_tick = 0, last-grant pointer = 1.
REQ-017 On rst_n deassertion, operation SHALL resume from IDLE on the next rising edge.
REQ-018 Reset asserted mid-frame SHALL abort the frame immediately, with no completion and no frame_tick.

Verification (DIV = 4, so 16 cycles per frame)
REQ-019 Bench SHALL cover these scenarios:
- Reset: rst_n = 0 -> all outputs at REQ-016 values within the same cycle; no clk edge needed.
- Single requester: req0 = 1, data0 = 16'h1234 from IDLE -> next cycle grant = 01, data = 1234, blank = 0, frame_tick = 1; digit_sel steps 0,1,2,3 every 4 cycles; frame_tick repeats every 16 cycles.
- Tie from IDLE: req0 = req1 = 1 -> grant = 01 first; then grant alternates 10, 01 at each FB; frame_tick at each switch.
- No tearing: change data0 to 16'hABCD mid-frame while owned -> data stays 1234 until the FB edge, then ABCD.
- Release: owner drops req with the other idle -> frame completes; at FB grant = 00, blank = 1, digit_sel = 0; data retains its last value.
- Mid-frame reset: assert rst_n = 0 at digit_sel = 2 -> immediate REQ-016 state; release with req1 = 1 -> grant = 10 one cycle after the first edge.
